regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters: the pipeline writeback stage and the UART receive path (UART→register loads).
- Writeback has priority. UART writes are buffered in a small FIFO.
- A starvation counter forces a UART drain slot and stalls writeback for that one cycle.
- A query port tells decode whether a source register still has a UART write pending, so decode can interlock.

---
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the writeback stage
// (priority) and a FIFO of UART receive writes, with a starvation-forced drain slot.
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_stall,
    input  logic                  uart_valid,
    input  logic [4:0]            uart_addr,
    input  logic [DATA_WIDTH-1:0] uart_data,
    output logic                  uart_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data,
    input  logic [4:0]            query_addr,
    output logic                  query_pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]            fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;
    logic                  rf_from_uart;

    logic empty;
    logic wb_req;
    logic push_en;
    logic pop_en;
    logic fifo_hit;

    assign empty      = (count == '0);
    assign uart_ready = (count < CNT_W'(FIFO_DEPTH));
    assign wb_stall   = (starve_cnt == STV_W'(STARVE_LIMIT)) && !empty;
    assign wb_req     = wb_valid && (wb_addr != 5'd0);
    // r0 writes are acknowledged but never stored.
    assign push_en    = uart_valid && uart_ready && (uart_addr != 5'd0);
    assign pop_en     = !empty && (wb_stall || !wb_req);

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        fifo_hit = 1'b0;
        offset   = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (fifo_addr[i] == query_addr))
                fifo_hit = 1'b1;
        end
    end

    assign query_pending = (query_addr != 5'd0) &&
                           (fifo_hit || (rf_we && rf_from_uart && (rf_addr == query_addr)));

    // NOTE: FIFO storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_addr[wr_ptr] <= uart_addr;
            fifo_data[wr_ptr] <= uart_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            rf_we        <= 1'b0;
            rf_addr      <= '0;
            rf_data      <= '0;
            rf_from_uart <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;

            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop_en) begin
                rf_we        <= 1'b1;
                rf_addr      <= fifo_addr[rd_ptr];
                rf_data      <= fifo_data[rd_ptr];
                rf_from_uart <= 1'b1;
                starve_cnt   <= '0;
            end else if (wb_req) begin
                rf_we        <= 1'b1;
                rf_addr      <= wb_addr;
                rf_data      <= wb_data;
                rf_from_uart <= 1'b0;
                if (empty)
                    starve_cnt <= '0;
                else if (starve_cnt != STV_W'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                rf_we        <= 1'b0;
                rf_from_uart <= 1'b0;
                starve_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected register-file writes are
// queued as stimulus is driven and compared as the write port fires.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        uart_valid;
    logic [4:0]  uart_addr;
    logic [31:0] uart_data;
    logic        uart_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [4:0]  query_addr;
    logic        query_pending;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    regfile_write_arbiter #(
        .FIFO_DEPTH  (4),
        .STARVE_LIMIT(8),
        .DATA_WIDTH  (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .uart_valid   (uart_valid),
        .uart_addr    (uart_addr),
        .uart_data    (uart_data),
        .uart_ready   (uart_ready),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .query_addr   (query_addr),
        .query_pending(query_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic q_check(input string tag, input logic [4:0] a, input logic e);
        query_addr = a;
        #1;
        chk(tag, 64'(query_pending), 64'(e));
    endtask

    task automatic idle_inputs();
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        uart_valid = 1'b0;
        uart_addr  = '0;
        uart_data  = '0;
    endtask

    task automatic drain_check(input string tag);
        idle_inputs();
        repeat (8) tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Write-port monitor: every rf_we pulse must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && rf_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write_addr", 64'(rf_addr), 64'h3F);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rf_addr), 64'(e.addr));
                chk("wr_data", 64'(rf_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  d;
        int  wi;
        int  uj;
        logic stall_seen;
        logic ready_seen;

        reset      = 1'b1;
        query_addr = 5'd3;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we",    64'(rf_we),         64'd0);
        chk("rst_addr",  64'(rf_addr),       64'd0);
        chk("rst_data",  64'(rf_data),       64'd0);
        chk("rst_ready", 64'(uart_ready),    64'd1);
        chk("rst_stall", 64'(wb_stall),      64'd0);
        chk("rst_qp",    64'(query_pending), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Unopposed UART write: accepted at edge a, written after edge a+1
        uart_valid = 1'b1;
        uart_addr  = 5'd3;
        uart_data  = 32'hDEADBEEF;
        query_addr = 5'd3;
        exp_push(5'd3, 32'hDEADBEEF);
        @(negedge clk);
        chk("qp_pre_accept", 64'(query_pending), 64'd0);
        tick();
        uart_valid = 1'b0;
        @(negedge clk);
        chk("uart_lat_we", 64'(rf_we),         64'd0);
        chk("qp_queued",   64'(query_pending), 64'd1);
        tick();
        @(negedge clk);
        chk("uart_we",     64'(rf_we),         64'd1);
        chk("qp_inflight", 64'(query_pending), 64'd1);
        tick();
        @(negedge clk);
        chk("we_drop",   64'(rf_we),         64'd0);
        chk("qp_done",   64'(query_pending), 64'd0);
        chk("addr_hold", 64'(rf_addr),       64'd3);
        chk("data_hold", 64'(rf_data),       64'hDEADBEEF);
        drain_check("drain_unopposed");

        // Reset mid-operation: two queued entries, starve_cnt at 5
        uart_valid = 1'b1;
        uart_addr  = 5'd3;
        uart_data  = 32'h33;
        tick();
        wb_valid = 1'b1;
        wb_addr  = 5'd1;
        for (int i = 0; i < 5; i++) begin
            wb_data = 32'(100 + i);
            exp_push(5'd1, 32'(100 + i));
            if (i == 0) begin
                uart_addr = 5'd5;
                uart_data = 32'h55;
            end else begin
                uart_valid = 1'b0;
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we",    64'(rf_we),      64'd0);
        chk("mid_rst_ready", 64'(uart_ready), 64'd1);
        chk("mid_rst_stall", 64'(wb_stall),   64'd0);
        q_check("mid_rst_qp3", 5'd3, 1'b0);
        q_check("mid_rst_qp5", 5'd5, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_write", 64'(rf_we), 64'd0);
            tick();
        end
        drain_check("drain_reset");

        // Starvation break: 8 writebacks, one forced UART slot, held request resumes
        uart_valid = 1'b1;
        uart_addr  = 5'd4;
        uart_data  = 32'h44;
        tick();
        uart_valid = 1'b0;
        wb_valid   = 1'b1;
        wb_addr    = 5'd1;
        d = 0;
        for (int i = 0; i < 11; i++) begin
            wb_data = 32'(d);
            if (i == 8) exp_push(5'd4, 32'h44);
            else        exp_push(5'd1, 32'(i < 8 ? i : i - 1));
            @(negedge clk);
            stall_seen = wb_stall;
            chk("starve_stall", 64'(wb_stall), 64'(i == 8));
            tick();
            if (!stall_seen) d++;
        end
        drain_check("drain_starve");

        // FIFO full: writeback hogs the port, fifth UART request waits for a slot
        exp_q.delete();
        for (int k = 0; k < 9; k++) exp_push(5'd2, 32'(200 + k));
        exp_push(5'd8, 32'h300);
        for (int k = 9; k < 12; k++) exp_push(5'd2, 32'(200 + k));
        for (int j = 1; j < 5; j++) exp_push(5'(8 + j), 32'(32'h300 + j));
        wi = 0;
        uj = 0;
        for (int c = 0; c < 13; c++) begin
            wb_valid = 1'b1;
            wb_addr  = 5'd2;
            wb_data  = 32'(200 + wi);
            if (uj < 5) begin
                uart_valid = 1'b1;
                uart_addr  = 5'(8 + uj);
                uart_data  = 32'(32'h300 + uj);
            end else begin
                uart_valid = 1'b0;
            end
            @(negedge clk);
            stall_seen = wb_stall;
            ready_seen = uart_ready;
            if (c <= 10)
                chk("full_ready", 64'(uart_ready), 64'((c < 4) || (c == 10)));
            chk("full_stall", 64'(wb_stall), 64'(c == 9));
            tick();
            if (ready_seen && uart_valid) uj++;
            if (!stall_seen) wi++;
        end
        chk("full_all_accepted", 64'(uj), 64'd5);
        drain_check("drain_full");

        // r0 handling: both requesters target r0
        uart_valid = 1'b1;
        uart_addr  = 5'd0;
        uart_data  = 32'h1;
        wb_valid   = 1'b1;
        wb_addr    = 5'd0;
        wb_data    = 32'h77;
        @(negedge clk);
        chk("r0_ready", 64'(uart_ready), 64'd1);
        q_check("r0_qp0", 5'd0, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("r0_no_write", 64'(rf_we), 64'd0);
            chk("r0_ready_after", 64'(uart_ready), 64'd1);
            tick();
        end
        drain_check("drain_r0");

        // Query with simultaneous push of 7 and pop of 5
        wb_valid   = 1'b1;
        wb_addr    = 5'd2;
        wb_data    = 32'h400;
        uart_valid = 1'b1;
        uart_addr  = 5'd5;
        uart_data  = 32'h505;
        exp_push(5'd2, 32'h400);
        tick();
        wb_data   = 32'h401;
        uart_addr = 5'd6;
        uart_data = 32'h606;
        exp_push(5'd2, 32'h401);
        tick();
        wb_valid  = 1'b0;
        uart_addr = 5'd7;
        uart_data = 32'h707;
        exp_push(5'd5, 32'h505);
        @(negedge clk);
        chk("q_ready_two", 64'(uart_ready), 64'd1);
        q_check("q5_queued", 5'd5, 1'b1);
        q_check("q7_not_yet", 5'd7, 1'b0);
        tick();
        uart_valid = 1'b0;
        wb_valid   = 1'b1;
        wb_data    = 32'h402;
        exp_push(5'd2, 32'h402);
        @(negedge clk);
        q_check("q5_inflight", 5'd5, 1'b1);
        q_check("q6_queued",   5'd6, 1'b1);
        q_check("q7_queued",   5'd7, 1'b1);
        tick();
        wb_valid = 1'b0;
        exp_push(5'd6, 32'h606);
        exp_push(5'd7, 32'h707);
        @(negedge clk);
        q_check("q5_done", 5'd5, 1'b0);
        q_check("q6_still", 5'd6, 1'b1);
        q_check("q7_still", 5'd7, 1'b1);
        drain_check("drain_query");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
